// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII Ethernet frame transmitter.
package ether_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        FCS,
        IPG
    } state_e;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;
    localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;

    typedef struct packed {
        logic       last;
        logic [1:0] dibit;
    } fifo_entry_t;

    // One bit of the reflected (LSB-first) CRC-32 shift.
    function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
        return (crc[0] ^ b) ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Combinational CRC-32 advance by one dibit, bit 0 first.
// Only built when ETHER_TX_FCS_EN is defined.
`ifdef ETHER_TX_FCS_EN
module crc32_dibit
    import ether_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [1:0]  dibit_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_bit(crc32_bit(crc_i, dibit_i[0]), dibit_i[1]);

endmodule
`endif

// File: rtl/ether_tx_rmii.sv
// RMII transmitter: preamble/SFD, FIFO-buffered payload, optional CRC-32 FCS, inter-packet gap.
// Define ETHER_TX_FCS_EN to append the FCS; otherwise upstream supplies its own.
module ether_tx_rmii
    import ether_pkg::*;
#(
    parameter int FIFO_DEPTH      = 64,
    parameter int PREAMBLE_DIBITS = 31,
    parameter int IPG_DIBITS      = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       preamble_signal,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       data_request,
    output logic       axiov,
    output logic [1:0] axiod
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CMAX0 = (PREAMBLE_DIBITS > IPG_DIBITS) ? PREAMBLE_DIBITS : IPG_DIBITS;
    localparam int CMAX  = (CMAX0 > 16) ? CMAX0 : 16;
    localparam int CW    = $clog2(CMAX) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    fifo_entry_t   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          hold_vld_q, hold_vld_d;
    logic [1:0]    hold_dat_q, hold_dat_d;
    logic          done_q, done_d;

    logic          axiov_q, axiov_d;
    logic [1:0]    axiod_q, axiod_d;
    logic          dreq_q, dreq_d;

    logic          start, active, fifo_empty, fifo_full, wr_req, do_wr, rd;
    fifo_entry_t   head, wr_ent;

    assign start      = (state_q == IDLE) && preamble_signal;
    assign active     = (state_q != IDLE) && (state_q != IPG);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW+1)'(FIFO_DEPTH));
    // A held dibit is committed one cycle late so its 'last' flag can see the next axiiv.
    assign wr_req     = active && !done_q && hold_vld_q;
    assign do_wr      = wr_req && !fifo_full;
    assign wr_ent     = {!axiiv, hold_dat_q};
    assign head       = mem_q[rptr_q];
    assign rd         = (state_q == DATA) && !fifo_empty;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        done_d     = done_q;
        if (start) begin
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            hold_vld_d = 1'b0;
            done_d     = 1'b0;
        end else begin
            if (do_wr) wptr_d = wptr_q + 1'b1;
            if (rd)    rptr_d = rptr_q + 1'b1;
            level_d = level_q + (AW+1)'(do_wr) - (AW+1)'(rd);
            if (active && !done_q) begin
                hold_vld_d = axiiv;
                hold_dat_d = axiid;
                if (wr_req && !axiiv) done_d = 1'b1;
            end else begin
                hold_vld_d = 1'b0;
            end
        end
    end

`ifdef ETHER_TX_FCS_EN
    logic [31:0] crc_q, crc_d, crc_nxt;

    crc32_dibit u_crc (
        .crc_i   (crc_q),
        .dibit_i (head.dibit),
        .crc_o   (crc_nxt)
    );

    // During FCS the register doubles as the output shifter.
    always_comb begin
        crc_d = crc_q;
        if (start)                 crc_d = CRC_INIT;
        else if (rd)               crc_d = crc_nxt;
        else if (state_q == FCS)   crc_d = crc_q >> 2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) crc_q <= CRC_INIT;
        else      crc_q <= crc_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        axiov_d = 1'b0;
        axiod_d = 2'b00;
        case (state_q)
            IDLE: begin
                if (preamble_signal) begin
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                end
            end
            PREAMBLE: begin
                axiov_d = 1'b1;
                axiod_d = PREAMBLE_DIBIT;
                if (cnt_q == CW'(PREAMBLE_DIBITS - 1)) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SFD: begin
                axiov_d = 1'b1;
                axiod_d = SFD_DIBIT;
                state_d = DATA;
            end
            DATA: begin
                cnt_d = '0;
                // Empty before 'last' means the source underran: abort, no FCS.
                if (fifo_empty) begin
                    state_d = IPG;
                end else begin
                    axiov_d = 1'b1;
                    axiod_d = head.dibit;
`ifdef ETHER_TX_FCS_EN
                    if (head.last) state_d = FCS;
`else
                    if (head.last) state_d = IPG;
`endif
                end
            end
`ifdef ETHER_TX_FCS_EN
            FCS: begin
                axiov_d = 1'b1;
                axiod_d = ~crc_q[1:0];
                if (cnt_q == CW'(15)) begin
                    state_d = IPG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            IPG: begin
                if (cnt_q == CW'(IPG_DIBITS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dreq_d = (state_q != IDLE) && (state_d != IDLE) && (state_d != IPG) && !done_d
                    && (level_d < (AW+1)'(FIFO_DEPTH - 4));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            hold_vld_q <= 1'b0;
            hold_dat_q <= 2'b00;
            done_q     <= 1'b0;
            axiov_q    <= 1'b0;
            axiod_q    <= 2'b00;
            dreq_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            hold_vld_q <= hold_vld_d;
            hold_dat_q <= hold_dat_d;
            done_q     <= done_d;
            axiov_q    <= axiov_d;
            axiod_q    <= axiod_d;
            dreq_q     <= dreq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_ent;
    end

    assign axiov        = axiov_q;
    assign axiod        = axiod_q;
    assign data_request = dreq_q;

endmodule

// File: tb/tb_ether_tx_rmii.sv
// Directed bench for ether_tx_rmii; FCS expectations follow ETHER_TX_FCS_EN.
module tb_ether_tx_rmii;

`ifdef ETHER_TX_FCS_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       preamble_signal = 1'b0;
    logic       axiiv = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic       data_request, axiov;
    logic [1:0] axiod;

    int tests = 0;
    int fails = 0;

    logic [1:0] pay      [4400];
    logic [2:0] rec      [4400];
    logic       dreq_rec [4400];

    always #10 clk = ~clk;

    ether_tx_rmii dut (
        .clk             (clk),
        .rst             (rst),
        .preamble_signal (preamble_signal),
        .axiiv           (axiiv),
        .axiid           (axiid),
        .data_request    (data_request),
        .axiov           (axiov),
        .axiod           (axiod)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 2; b++)
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic drive(input int c, input int gap, input int n, input int pulse_at);
        preamble_signal = (c == pulse_at);
        if (c >= gap && c < gap + n) begin
            axiiv = 1'b1;
            axiid = pay[c - gap];
        end else begin
            axiiv = 1'b0;
            axiid = 2'b00;
        end
    endtask

    // Pulse sampled at edge N; cycle c below is the cycle after edge N+c.
    task automatic run_frame(input int gap, input int n, input int ncyc, input int pulse_at);
        preamble_signal = 1'b1;
        axiiv = 1'b1;
        axiid = 2'b10;
        tick();
        drive(0, gap, n, pulse_at);
        dreq_rec[0] = data_request;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            rec[c]      = {axiov, axiod};
            dreq_rec[c] = data_request;
            drive(c, gap, n, pulse_at);
        end
        axiiv = 1'b0;
        preamble_signal = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n, input int ncyc);
        int          bad, first;
        logic [2:0]  e;
        logic [31:0] crc, fcs;
        bad = 0;
        first = 0;
        crc = 32'hFFFFFFFF;
        for (int j = 0; j < n; j++) crc = crc_upd(crc, pay[j]);
        fcs = ~crc;
        for (int c = 1; c <= ncyc; c++) begin
            if (c <= 31)                              e = 3'b101;
            else if (c == 32)                         e = 3'b111;
            else if (c <= 32 + n)                     e = {1'b1, pay[c - 33]};
            else if (FCS_EN && n > 0 && c <= 48 + n)  e = {1'b1, fcs[2*(c-33-n) +: 2]};
            else                                      e = 3'b000;
            if (rec[c] !== e) begin
                if (bad == 0) first = c;
                bad++;
            end
        end
        chk($sformatf("%s stream bad-cycles (first at %0d)", tag, first), bad, 0);
`ifdef ETHER_TX_FCS_EN
        if (n > 0) begin
            logic [31:0] r, rev;
            logic [2:0]  o;
            r = 32'hFFFFFFFF;
            for (int j = 0; j < n; j++) r = crc_upd(r, pay[j]);
            for (int k = 0; k < 16; k++) begin
                o = rec[33 + n + k];
                r = crc_upd(r, o[1:0]);
            end
            for (int i = 0; i < 32; i++) rev[i] = r[31 - i];
            chk({tag, " residue"}, rev, 32'hC704DD7B);
        end
`endif
    endtask

    initial begin
        int bad;
        logic [7:0] byt;

        // 1: reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            tick();
            preamble_signal = 1'($urandom);
            axiiv = 1'($urandom);
            axiid = 2'($urandom);
            chk("reset axiov", {31'd0, axiov}, 0);
            chk("reset axiod", {30'd0, axiod}, 0);
            chk("reset data_request", {31'd0, data_request}, 0);
        end
        preamble_signal = 1'b0;
        axiiv = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        // 2+5: no payload -> underrun abort; pulses inside IPG ignored
        run_frame(1000, 0, 79, 40);
        check_stream("underrun", 0, 79);
        tick();                                  // cycle N+80, last IPG cycle
        chk("ipg tail axiov", {31'd0, axiov}, 0);
        preamble_signal = 1'b1;
        tick();                                  // cycle N+81, first IDLE cycle
        chk("idle axiov", {31'd0, axiov}, 0);
        tick();                                  // edge N+82 accepted the pulse
        preamble_signal = 1'b0;
        chk("pulse in last IPG cycle ignored", {31'd0, axiov}, 0);
        tick();
        chk("b2b start", {29'd0, axiov, axiod}, 3'b101);
        bad = 0;
        for (int c = 2; c <= 100; c++) begin
            tick();
            if ({axiov, axiod} !== ((c <= 31) ? 3'b101 : (c == 32) ? 3'b111 : 3'b000)) bad++;
        end
        chk("b2b frame shape", bad, 0);

        // 3: 4096-dibit diagonal pattern, payload from N+5, stray pulse in DATA
        for (int i = 0; i < 1024; i++) begin
            byt = ((i / 32) == (i % 32)) ? 8'h00 : 8'hFF;
            for (int k = 0; k < 4; k++) pay[4*i + k] = byt[2*k +: 2];
        end
        run_frame(5, 4096, 32 + 4096 + 16 + 52, 200);
        check_stream("diag4096", 4096, 32 + 4096 + 16 + 52);
        chk("dreq idle", {31'd0, dreq_rec[0]}, 0);
        chk("dreq first", {31'd0, dreq_rec[1]}, 1);
        chk("dreq before last", {31'd0, dreq_rec[5 + 4096 - 1]}, 1);
        chk("dreq after last", {31'd0, dreq_rec[5 + 4096 + 3]}, 0);

        // 4: 60 bytes of zero
        for (int j = 0; j < 240; j++) pay[j] = 2'b00;
        run_frame(3, 240, 32 + 240 + 16 + 52, -1);
        check_stream("zeros60", 240, 32 + 240 + 16 + 52);

        // random payload captured from the very first enabled cycle
        for (int j = 0; j < 37; j++) pay[j] = 2'($urandom);
        pay[0] = 2'b01;
        pay[1] = 2'b10;
        run_frame(0, 37, 32 + 37 + 16 + 52, -1);
        check_stream("rand37", 37, 32 + 37 + 16 + 52);

        // 6: async reset mid-DATA
        for (int j = 0; j < 100; j++) pay[j] = 2'($urandom);
        preamble_signal = 1'b1;
        tick();
        preamble_signal = 1'b0;
        axiiv = 1'b1;
        axiid = pay[0];
        for (int c = 1; c <= 50; c++) begin
            tick();
            axiid = pay[c];
        end
        chk("pre-reset axiov", {31'd0, axiov}, 1);
        #4 rst = 1'b0;
        #1;
        chk("async reset axiov", {31'd0, axiov}, 0);
        chk("async reset axiod", {30'd0, axiod}, 0);
        chk("async reset dreq", {31'd0, data_request}, 0);
        repeat (3) tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (axiov !== 1'b0 || axiod !== 2'b00 || data_request !== 1'b0) bad++;
        end
        chk("post-reset idle", bad, 0);
        axiiv = 1'b0;
        for (int j = 0; j < 20; j++) pay[j] = 2'($urandom);
        run_frame(2, 20, 32 + 20 + 16 + 52, -1);
        check_stream("post-reset frame", 20, 32 + 20 + 16 + 52);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
